mem_stage: RTL and testbench

- Memory-access pipeline stage; sits between exe_stage and wb_stage.
- Latches the EX result bus, waits for the data-SRAM read response on loads, then extracts and extends the load data (byte, halfword or word).
- Drives the 70-bit MS-to-WS bus that wb_stage consumes.
- Publishes a hazard bus so the ID-stage blocking logic can stall dependent instructions; there is no forwarding.

---
 rtl/mem_stage.sv | 156 +++++++++++++++
 tb/tb_mem_stage.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// mem_stage: memory-access pipeline stage between exe_stage and wb_stage.
// Latches the EX result bus, waits for the data-SRAM read response on loads,
// extracts/extends the load data and drives the MS-to-WS and hazard buses.
module mem_stage #(
  parameter int USE_DATA_OK     = 1,
  parameter int ES_TO_MS_BUS_WD = 74,
  parameter int MS_TO_WS_BUS_WD = 70,
  parameter int HAZARD_BUS_WD   = 7
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       ws_allowin,
  output logic                       ms_allowin,
  input  logic                       es_to_ms_valid,
  input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
  output logic                       ms_to_ws_valid,
  output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
  input  logic                       data_sram_data_ok,
  input  logic [31:0]                data_sram_rdata,
  output logic [HAZARD_BUS_WD-1:0]   ms_hazard_bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_HELD = 2'd2
  } state_t;

  state_t                     state;
  state_t                     state_next;
  logic                       ms_valid;
  logic                       ms_ready_go;
  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus_r;
  logic [31:0]                rdata_buf;
  logic                       buf_load;
  logic                       in_load;

  logic [2:0]  ms_load_type;
  logic        ms_res_from_mem;
  logic        ms_gr_we;
  logic [4:0]  ms_dest;
  logic [31:0] ms_alu_result;
  logic [31:0] ms_pc;

  logic [31:0] ld_rdata;
  logic [1:0]  sel;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] load_data;
  logic [31:0] final_result;

  assign ms_load_type    = es_to_ms_bus_r[73:71];
  assign ms_res_from_mem = es_to_ms_bus_r[70];
  assign ms_gr_we        = es_to_ms_bus_r[69];
  assign ms_dest         = es_to_ms_bus_r[68:64];
  assign ms_alu_result   = es_to_ms_bus_r[63:32];
  assign ms_pc           = es_to_ms_bus_r[31:0];

  // Stage handshake: a load may only leave once its read data is available
  always_comb begin
    ms_ready_go = 1'b1;
    if (ms_res_from_mem && (USE_DATA_OK != 0)) begin
      ms_ready_go = (state == S_HELD) || data_sram_data_ok;
    end
  end

  assign ms_allowin     = !ms_valid || (ms_ready_go && ws_allowin);
  assign ms_to_ws_valid = ms_valid && ms_ready_go;
  assign in_load        = es_to_ms_valid && ms_allowin && es_to_ms_bus[70];

  // Stage valid bit
  always_ff @(posedge clk) begin
    if (!reset) begin
      ms_valid <= 1'b0;
    end else if (ms_allowin) begin
      ms_valid <= es_to_ms_valid;
    end
  end

  // EX-to-MS bus register; contents are don't-care while ms_valid is low
  always_ff @(posedge clk) begin
    if (es_to_ms_valid && ms_allowin) begin
      es_to_ms_bus_r <= es_to_ms_bus;
    end
  end

  // Read-data buffer, captured when data arrives but WB cannot accept it
  always_ff @(posedge clk) begin
    if (buf_load) begin
      rdata_buf <= data_sram_rdata;
    end
  end

  // Load FSM state register
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Load FSM next state; the incoming instruction decides the state on a
  // simultaneous leave/enter. data_ok outside WAIT is discarded.
  always_comb begin
    state_next = state;
    buf_load   = 1'b0;
    if (USE_DATA_OK != 0) begin
      case (state)
        S_IDLE: begin
          if (in_load) state_next = S_WAIT;
        end
        S_WAIT: begin
          if (data_sram_data_ok) begin
            if (ws_allowin) begin
              state_next = in_load ? S_WAIT : S_IDLE;
            end else begin
              state_next = S_HELD;
              buf_load   = 1'b1;
            end
          end
        end
        S_HELD: begin
          if (ws_allowin) state_next = in_load ? S_WAIT : S_IDLE;
        end
        default: state_next = S_IDLE;
      endcase
    end
  end

  // Load data extraction and extension
  always_comb begin
    ld_rdata = data_sram_rdata;
    if ((USE_DATA_OK != 0) && (state == S_HELD)) ld_rdata = rdata_buf;
    sel = ms_alu_result[1:0];
    case (sel)
      2'd0:    ld_byte = ld_rdata[7:0];
      2'd1:    ld_byte = ld_rdata[15:8];
      2'd2:    ld_byte = ld_rdata[23:16];
      default: ld_byte = ld_rdata[31:24];
    endcase
    ld_half = sel[1] ? ld_rdata[31:16] : ld_rdata[15:0];
    case (ms_load_type)
      3'b001:  load_data = {{24{ld_byte[7]}}, ld_byte};
      3'b010:  load_data = {24'h000000, ld_byte};
      3'b011:  load_data = {{16{ld_half[15]}}, ld_half};
      3'b100:  load_data = {16'h0000, ld_half};
      default: load_data = ld_rdata;
    endcase
    final_result = ms_res_from_mem ? load_data : ms_alu_result;
  end

  assign ms_to_ws_bus  = {ms_gr_we, ms_dest, final_result, ms_pc};
  assign ms_hazard_bus = {ms_valid, ms_gr_we, ms_dest};

endmodule

// File: tb/tb_mem_stage.sv
// Directed, table-driven bench for mem_stage with hand-computed expectations.
module tb_mem_stage;

  logic        clk;
  logic        reset;
  logic        ws_allowin;
  logic        ms_allowin;
  logic        es_to_ms_valid;
  logic [73:0] es_to_ms_bus;
  logic        ms_to_ws_valid;
  logic [69:0] ms_to_ws_bus;
  logic        data_sram_data_ok;
  logic [31:0] data_sram_rdata;
  logic [6:0]  ms_hazard_bus;

  int n_checks;
  int n_fail;

  mem_stage #(
    .USE_DATA_OK    (1),
    .ES_TO_MS_BUS_WD(74),
    .MS_TO_WS_BUS_WD(70),
    .HAZARD_BUS_WD  (7)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .ws_allowin       (ws_allowin),
    .ms_allowin       (ms_allowin),
    .es_to_ms_valid   (es_to_ms_valid),
    .es_to_ms_bus     (es_to_ms_bus),
    .ms_to_ws_valid   (ms_to_ws_valid),
    .ms_to_ws_bus     (ms_to_ws_bus),
    .data_sram_data_ok(data_sram_data_ok),
    .data_sram_rdata  (data_sram_rdata),
    .ms_hazard_bus    (ms_hazard_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  lt;
    logic        rfm;
    logic        we;
    logic [4:0]  dest;
    logic [31:0] alu;
    logic [31:0] pc;
    logic [31:0] rdata;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[14];

  function automatic logic [73:0] mk(input logic [2:0] lt, input logic rfm, input logic we,
                                     input logic [4:0] dest, input logic [31:0] alu,
                                     input logic [31:0] pc);
    return {lt, rfm, we, dest, alu, pc};
  endfunction

  task automatic chk(input string name, input logic [69:0] act, input logic [69:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset = 1'b0;
    ws_allowin = 1'b1;
    es_to_ms_valid = 1'b0;
    es_to_ms_bus = '0;
    data_sram_data_ok = 1'b0;
    data_sram_rdata = '0;

    //            lt     rfm   we    dest  alu           pc            rdata         exp
    vecs[0]  = '{3'b000, 1'b0, 1'b1, 5'd5, 32'h00001234, 32'hBFC00000, 32'h80FF7F01, 32'h00001234};
    vecs[1]  = '{3'b001, 1'b1, 1'b1, 5'd2, 32'h00001003, 32'hBFC00004, 32'h80FF7F01, 32'hFFFFFF80};
    vecs[2]  = '{3'b010, 1'b1, 1'b1, 5'd3, 32'h00001003, 32'hBFC00008, 32'h80FF7F01, 32'h00000080};
    vecs[3]  = '{3'b001, 1'b1, 1'b1, 5'd4, 32'h00001002, 32'hBFC0000C, 32'h80FF7F01, 32'hFFFFFFFF};
    vecs[4]  = '{3'b010, 1'b1, 1'b1, 5'd6, 32'h00001002, 32'hBFC00010, 32'h80FF7F01, 32'h000000FF};
    vecs[5]  = '{3'b011, 1'b1, 1'b1, 5'd7, 32'h00001000, 32'hBFC00014, 32'h80FF7F01, 32'h00007F01};
    vecs[6]  = '{3'b100, 1'b1, 1'b1, 5'd8, 32'h00001002, 32'hBFC00018, 32'h80FF7F01, 32'h000080FF};
    vecs[7]  = '{3'b011, 1'b1, 1'b1, 5'd9, 32'h00001002, 32'hBFC0001C, 32'h80FF7F01, 32'hFFFF80FF};
    vecs[8]  = '{3'b000, 1'b1, 1'b1, 5'd10, 32'h00001000, 32'hBFC00020, 32'h80FF7F01, 32'h80FF7F01};
    vecs[9]  = '{3'b011, 1'b1, 1'b1, 5'd11, 32'h00001003, 32'hBFC00024, 32'h80FF7F01, 32'hFFFF80FF};
    vecs[10] = '{3'b001, 1'b1, 1'b0, 5'd12, 32'h00001000, 32'hBFC00028, 32'h80FF7F01, 32'h00000001};
    vecs[11] = '{3'b010, 1'b1, 1'b1, 5'd13, 32'h00001001, 32'hBFC0002C, 32'h80FF7F01, 32'h0000007F};
    vecs[12] = '{3'b101, 1'b1, 1'b1, 5'd14, 32'h00001002, 32'hBFC00030, 32'h80FF7F01, 32'h80FF7F01};
    vecs[13] = '{3'b100, 1'b1, 1'b1, 5'd31, 32'h00001001, 32'hBFC00034, 32'h80FF7F01, 32'h00007F01};

    // reset state
    @(negedge clk);
    #1;
    chk("reset_ms_to_ws_valid", {69'd0, ms_to_ws_valid}, 70'd0);
    chk("reset_hazard_valid", {69'd0, ms_hazard_bus[6]}, 70'd0);
    chk("reset_allowin", {69'd0, ms_allowin}, 70'd1);
    @(negedge clk);
    reset = 1'b1;

    // table: each instruction enters, data_ok on its first cycle in MS
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      es_to_ms_valid = 1'b1;
      es_to_ms_bus = mk(vecs[i].lt, vecs[i].rfm, vecs[i].we, vecs[i].dest, vecs[i].alu, vecs[i].pc);
      ws_allowin = 1'b1;
      data_sram_data_ok = 1'b0;
      #1;
      chk($sformatf("vec%0d_allowin_empty", i), {69'd0, ms_allowin}, 70'd1);
      @(negedge clk);
      es_to_ms_valid = 1'b0;
      data_sram_data_ok = 1'b1;
      data_sram_rdata = vecs[i].rdata;
      #1;
      chk($sformatf("vec%0d_valid", i), {69'd0, ms_to_ws_valid}, 70'd1);
      chk($sformatf("vec%0d_bus", i), ms_to_ws_bus,
          {vecs[i].we, vecs[i].dest, vecs[i].exp, vecs[i].pc});
      chk($sformatf("vec%0d_hazard", i), {63'd0, ms_hazard_bus}, {63'd0, 1'b1, vecs[i].we, vecs[i].dest});
      @(negedge clk);
      data_sram_data_ok = 1'b0;
      #1;
      chk($sformatf("vec%0d_left", i), {69'd0, ms_to_ws_valid}, 70'd0);
    end

    // data_ok wait of 3 cycles
    @(negedge clk);
    es_to_ms_valid = 1'b1;
    es_to_ms_bus = mk(3'b011, 1'b1, 1'b1, 5'd17, 32'h00002002, 32'hBFC00100);
    @(negedge clk);
    es_to_ms_valid = 1'b0;
    data_sram_rdata = 32'h5A5A8001;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("wait%0d_valid", c), {69'd0, ms_to_ws_valid}, 70'd0);
      chk($sformatf("wait%0d_allowin", c), {69'd0, ms_allowin}, 70'd0);
      chk($sformatf("wait%0d_hazard", c), {63'd0, ms_hazard_bus}, {63'd0, 7'b1_1_10001});
      @(negedge clk);
    end
    data_sram_data_ok = 1'b1;
    #1;
    chk("wait_done_valid", {69'd0, ms_to_ws_valid}, 70'd1);
    chk("wait_done_bus", ms_to_ws_bus, {1'b1, 5'd17, 32'h00005A5A, 32'hBFC00100});
    @(negedge clk);
    data_sram_data_ok = 1'b0;

    // backpressure capture into buffer
    es_to_ms_valid = 1'b1;
    es_to_ms_bus = mk(3'b000, 1'b1, 1'b1, 5'd20, 32'h00003000, 32'hBFC00200);
    @(negedge clk);
    es_to_ms_valid = 1'b0;
    ws_allowin = 1'b0;
    data_sram_data_ok = 1'b1;
    data_sram_rdata = 32'hDEADBEEF;
    #1;
    chk("bp_dataok_valid", {69'd0, ms_to_ws_valid}, 70'd1);
    chk("bp_dataok_allowin", {69'd0, ms_allowin}, 70'd0);
    @(negedge clk);
    data_sram_data_ok = 1'b0;
    data_sram_rdata = 32'h00000000;
    #1;
    chk("bp_held_valid", {69'd0, ms_to_ws_valid}, 70'd1);
    chk("bp_held_result", {38'd0, ms_to_ws_bus[63:32]}, {38'd0, 32'hDEADBEEF});
    chk("bp_held_allowin", {69'd0, ms_allowin}, 70'd0);
    @(negedge clk);
    data_sram_data_ok = 1'b1;
    data_sram_rdata = 32'h11111111;
    #1;
    chk("bp_held_ignore_dataok", {38'd0, ms_to_ws_bus[63:32]}, {38'd0, 32'hDEADBEEF});
    @(negedge clk);
    data_sram_data_ok = 1'b0;
    ws_allowin = 1'b1;
    #1;
    chk("bp_leave_bus", ms_to_ws_bus, {1'b1, 5'd20, 32'hDEADBEEF, 32'hBFC00200});
    chk("bp_leave_allowin", {69'd0, ms_allowin}, 70'd1);
    @(negedge clk);
    #1;
    chk("bp_gone_valid", {69'd0, ms_to_ws_valid}, 70'd0);
    chk("bp_gone_hazard", {69'd0, ms_hazard_bus[6]}, 70'd0);

    // simultaneous leave and enter of two loads
    es_to_ms_valid = 1'b1;
    es_to_ms_bus = mk(3'b010, 1'b1, 1'b1, 5'd21, 32'h00004001, 32'hBFC00300);
    @(negedge clk);
    es_to_ms_bus = mk(3'b001, 1'b1, 1'b1, 5'd22, 32'h00004003, 32'hBFC00304);
    data_sram_data_ok = 1'b1;
    data_sram_rdata = 32'h12348856;
    #1;
    chk("swap_a_bus", ms_to_ws_bus, {1'b1, 5'd21, 32'h00000088, 32'hBFC00300});
    chk("swap_a_allowin", {69'd0, ms_allowin}, 70'd1);
    @(negedge clk);
    es_to_ms_valid = 1'b0;
    data_sram_data_ok = 1'b0;
    #1;
    chk("swap_b_waiting", {69'd0, ms_to_ws_valid}, 70'd0);
    chk("swap_b_hazard", {63'd0, ms_hazard_bus}, {63'd0, 7'b1_1_10110});
    @(negedge clk);
    data_sram_data_ok = 1'b1;
    data_sram_rdata = 32'h9A000000;
    #1;
    chk("swap_b_bus", ms_to_ws_bus, {1'b1, 5'd22, 32'hFFFFFF9A, 32'hBFC00304});
    @(negedge clk);
    data_sram_data_ok = 1'b0;

    // non-load stalled by WB; data_ok during it is discarded
    es_to_ms_valid = 1'b1;
    es_to_ms_bus = mk(3'b000, 1'b0, 1'b1, 5'd7, 32'h0000AAAA, 32'hBFC00400);
    @(negedge clk);
    es_to_ms_bus = mk(3'b000, 1'b0, 1'b1, 5'd9, 32'h00005555, 32'hBFC00404);
    ws_allowin = 1'b0;
    data_sram_data_ok = 1'b1;
    #1;
    chk("stall_valid", {69'd0, ms_to_ws_valid}, 70'd1);
    chk("stall_allowin", {69'd0, ms_allowin}, 70'd0);
    @(negedge clk);
    es_to_ms_valid = 1'b0;
    data_sram_data_ok = 1'b0;
    ws_allowin = 1'b1;
    #1;
    chk("stall_bus_held", ms_to_ws_bus, {1'b1, 5'd7, 32'h0000AAAA, 32'hBFC00400});
    @(negedge clk);
    es_to_ms_valid = 1'b1;
    es_to_ms_bus = mk(3'b000, 1'b1, 1'b1, 5'd3, 32'h00005000, 32'hBFC00408);
    @(negedge clk);
    es_to_ms_valid = 1'b0;
    #1;
    chk("stall_next_load_waits", {69'd0, ms_to_ws_valid}, 70'd0);
    @(negedge clk);
    data_sram_data_ok = 1'b1;
    data_sram_rdata = 32'h76543210;
    #1;
    chk("stall_next_load_bus", ms_to_ws_bus, {1'b1, 5'd3, 32'h76543210, 32'hBFC00408});
    @(negedge clk);
    data_sram_data_ok = 1'b0;

    // reset while waiting, then a late data_ok
    es_to_ms_valid = 1'b1;
    es_to_ms_bus = mk(3'b000, 1'b1, 1'b1, 5'd25, 32'h00006000, 32'hBFC00500);
    @(negedge clk);
    es_to_ms_valid = 1'b0;
    #1;
    chk("rst_pre_hazard", {69'd0, ms_hazard_bus[6]}, 70'd1);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rst_valid", {69'd0, ms_to_ws_valid}, 70'd0);
    chk("rst_hazard", {69'd0, ms_hazard_bus[6]}, 70'd0);
    chk("rst_allowin", {69'd0, ms_allowin}, 70'd1);
    @(negedge clk);
    data_sram_data_ok = 1'b1;
    data_sram_rdata = 32'hCAFEF00D;
    #1;
    chk("rst_late_dataok", {69'd0, ms_to_ws_valid}, 70'd0);
    @(negedge clk);
    data_sram_data_ok = 1'b0;
    es_to_ms_valid = 1'b1;
    es_to_ms_bus = mk(3'b000, 1'b1, 1'b1, 5'd26, 32'h00006004, 32'hBFC00504);
    @(negedge clk);
    es_to_ms_valid = 1'b0;
    #1;
    chk("rst_after_load_waits", {69'd0, ms_to_ws_valid}, 70'd0);
    @(negedge clk);
    data_sram_data_ok = 1'b1;
    data_sram_rdata = 32'h0BADF00D;
    #1;
    chk("rst_after_load_bus", ms_to_ws_bus, {1'b1, 5'd26, 32'h0BADF00D, 32'hBFC00504});
    @(negedge clk);
    data_sram_data_ok = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
